// File: rtl/sipo_sr.sv
// -----------------------------------------------------------------------------
// sipo_sr -- serial-in / parallel-out shift register with word framing.
//
// Shifts one serial bit into a WIDTH-bit register on every rising clk edge
// (no enable). A bit counter frames the stream into WIDTH-bit words, and a
// registered one-cycle word_valid pulse marks the cycle in which q holds a
// complete fresh word.
//
// Parameters
//   WIDTH     : number of shift stages / width of q (legal range 2..32)
//   MSB_FIRST : 1 = new bit enters q[0] and moves toward q[WIDTH-1]
//               0 = new bit enters q[WIDTH-1] and moves toward q[0]
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset asserted)
//   data_in    in   serial data bit, sampled every edge
//   q          out  parallel register contents (flop outputs)
//   word_valid out  one-cycle pulse after the edge completing a word
//   bit_cnt    out  bits shifted in since reset / last word boundary
// -----------------------------------------------------------------------------
module sipo_sr #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         data_in,
  output logic [WIDTH-1:0]             q,
  output logic                         word_valid,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_q;
  logic             valid_d;
  logic             word_done_s;

  // Shift direction is fixed at elaboration; data_in is taken as-is so X/Z
  // propagates into q without filtering.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_d = {shift_q[WIDTH-2:0], data_in};
    end else begin : g_lsb_first
      assign shift_d = {data_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  // The edge that shifts in the last bit of a word wraps the counter to 0
  // and raises word_valid for the following cycle.
  assign word_done_s = (cnt_q == LAST_BIT);
  assign cnt_d       = word_done_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1'b1));
  assign valid_d     = word_done_s;

  // Shift register: unconditional shift every edge, cleared by async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= {WIDTH{1'b0}};
    end else begin
      shift_q <= shift_d;
    end
  end

  // Word framing: bit counter and registered word_valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign q          = shift_q;
  assign bit_cnt    = cnt_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_sipo_sr.sv
// -----------------------------------------------------------------------------
// tb_sipo_sr -- directed self-checking bench for sipo_sr.
// dut4 : WIDTH=4, MSB_FIRST=1 ; dut8 : WIDTH=8, MSB_FIRST=0.
// Both share clk, reset and data_in.
// -----------------------------------------------------------------------------
module tb_sipo_sr;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [3:0] q4;
  logic       wv4;
  logic [2:0] cnt4;
  logic [7:0] q8;
  logic       wv8;
  logic [3:0] cnt8;

  int checks   = 0;
  int failures = 0;

  // reference history for the random stream
  logic hist [0:1023];
  int   nbits;

  sipo_sr #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in),
    .q(q4), .word_valid(wv4), .bit_cnt(cnt4)
  );

  sipo_sr #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .data_in(data_in),
    .q(q8), .word_valid(wv8), .bit_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a bit in the middle of the low phase, then move to 1 ns after the edge.
  task automatic shift_bit(input logic b);
    if (clk === 1'b1) begin
      @(negedge clk);
      #2;
    end
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Assert reset asynchronously in the low phase, check zeros, release.
  task automatic do_reset();
    if (clk === 1'b1) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_q4", {28'd0, q4}, 32'd0);
    chk("rst_cnt4", {29'd0, cnt4}, 32'd0);
    chk("rst_q8", {24'd0, q8}, 32'd0);
    #1;
    reset = 1'b1;
  endtask

  // check dut4 outputs against hand-computed values
  task automatic chk4(input string tag, input logic [3:0] eq, input logic [2:0] ec, input logic ev);
    chk({tag, "_q"},   {28'd0, q4},   {28'd0, eq});
    chk({tag, "_cnt"}, {29'd0, cnt4}, {29'd0, ec});
    chk({tag, "_wv"},  {31'd0, wv4},  {31'd0, ev});
  endtask

  initial begin
    logic [3:0] v_q;
    logic [2:0] v_c;
    logic [7:0] e8;
    logic [3:0] e4;
    logic       b;

    reset   = 1'b1;
    data_in = 1'b0;
    #1;
    reset = 1'b0;

    // reset held for 12 ns, data toggling, edge at 5 ns must do nothing
    for (int i = 0; i < 12; i++) begin
      #1;
      data_in = ~data_in;
      chk("hold_q", {28'd0, q4}, 32'd0);
      chk("hold_cnt", {29'd0, cnt4}, 32'd0);
      chk("hold_wv", {31'd0, wv4}, 32'd0);
    end
    reset = 1'b1;   // t=13, clk low; next edge at 15 is bit 1

    // 1,0,1,1 after release
    shift_bit(1'b1); chk4("s1", 4'b0001, 3'd1, 1'b0);
    shift_bit(1'b0); chk4("s2", 4'b0010, 3'd2, 1'b0);
    shift_bit(1'b1); chk4("s3", 4'b0101, 3'd3, 1'b0);
    shift_bit(1'b1); chk4("s4", 4'b1011, 3'd0, 1'b1);
    shift_bit(1'b0); chk4("s5", 4'b0110, 3'd1, 1'b0);

    // eight consecutive ones after reset
    do_reset();
    v_q = 4'b0000;
    for (int i = 1; i <= 8; i++) begin
      shift_bit(1'b1);
      v_q = (i >= 4) ? 4'b1111 : ((4'b0001 << i) - 4'd1);
      v_c = 3'(i % 4);
      chk4($sformatf("ones%0d", i), v_q, v_c, (i % 4) == 0);
    end

    // build q=0110 with bit_cnt=2, then reset between edges
    do_reset();
    shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1);
    chk4("pre_w", 4'b0001, 3'd0, 1'b1);
    shift_bit(1'b1);
    shift_bit(1'b0);
    chk4("mid", 4'b0110, 3'd2, 1'b0);
    #2;               // high phase, between edges
    reset = 1'b0;
    #1;
    chk4("async", 4'b0000, 3'd0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    shift_bit(1'b1); chk4("r1", 4'b0001, 3'd1, 1'b0);
    shift_bit(1'b0); chk4("r2", 4'b0010, 3'd2, 1'b0);
    shift_bit(1'b1); chk4("r3", 4'b0101, 3'd3, 1'b0);
    shift_bit(1'b1); chk4("r4", 4'b1011, 3'd0, 1'b1);

    // WIDTH=8, LSB-entry instance: 1 then seven 0s
    do_reset();
    shift_bit(1'b1);
    chk("w8_b1_q", {24'd0, q8}, 32'h80);
    chk("w8_b1_cnt", {28'd0, cnt8}, 32'd1);
    for (int i = 2; i <= 7; i++) shift_bit(1'b0);
    chk("w8_b7_q", {24'd0, q8}, 32'h02);
    chk("w8_b7_wv", {31'd0, wv8}, 32'd0);
    shift_bit(1'b0);
    chk("w8_b8_q", {24'd0, q8}, 32'h01);
    chk("w8_b8_wv", {31'd0, wv8}, 32'd1);
    chk("w8_b8_cnt", {28'd0, cnt8}, 32'd0);

    // 200 random bits against a history-based reference
    do_reset();
    nbits = 0;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(0, 1));
      shift_bit(b);
      hist[nbits] = b;
      nbits++;
      e4 = 4'd0;
      for (int k = 0; k < 4; k++)
        if (k < nbits) e4[k] = hist[nbits-1-k];
      e8 = 8'd0;
      for (int k = 0; k < 8; k++)
        if (k < nbits) e8[7-k] = hist[nbits-1-k];
      chk("rnd_q4", {28'd0, q4}, {28'd0, e4});
      chk("rnd_cnt4", {29'd0, cnt4}, 32'(nbits % 4));
      chk("rnd_wv4", {31'd0, wv4}, {31'd0, (nbits % 4) == 0});
      chk("rnd_q8", {24'd0, q8}, {24'd0, e8});
      chk("rnd_cnt8", {28'd0, cnt8}, 32'(nbits % 8));
      chk("rnd_wv8", {31'd0, wv8}, {31'd0, (nbits % 8) == 0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_sr.md
SIPO_SR -- requirements
Module: sipo_sr

Interface
REQ-001 Parameter WIDTH, default 4, number of shift stages and width of q; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = new bit enters q[0] and shifts toward q[WIDTH-1]; 0 = new bit enters q[WIDTH-1] and shifts toward q[0].
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 Port data_in  input  1  serial data bit, sampled on every rising clk edge while reset is deasserted.
REQ-006 Port q  output  WIDTH  parallel register contents, driven directly from flops.
REQ-007 Port word_valid  output  1  one-cycle pulse marking that q holds WIDTH fresh bits since reset or since the previous pulse.
REQ-008 Port bit_cnt  output  $clog2(WIDTH+1)  number of bits shifted in since reset or since the last word boundary.

Function
REQ-009 Every rising clk edge with reset high SHALL shift q by one position and insert data_in (MSB_FIRST=1: q <= {q[WIDTH-2:0], data_in}).
REQ-010 Shift SHALL be unconditional: there is no enable, and q advances every cycle.
REQ-011 Latency SHALL be one edge: a data_in value sampled at edge N SHALL be visible in q immediately after edge N.
REQ-012 With MSB_FIRST=1, after WIDTH edges the first-shifted bit SHALL sit in q[WIDTH-1] and the last in q[0].
REQ-013 bit_cnt SHALL increment by 1 per edge and wrap from WIDTH-1 to 0 on the edge that completes a word.
REQ-014 word_valid SHALL be registered and SHALL be 1 for exactly the cycle following the edge that shifts in the WIDTH-th bit of a word; otherwise 0.
REQ-015 Bits older than WIDTH edges SHALL be discarded off the far end; there is no overflow indication.
REQ-016 data_in SHALL be sampled as-is; X/Z on data_in propagates into q, with no filtering.

Reset
REQ-017 reset low SHALL immediately, without waiting for clk, force q=0, bit_cnt=0 and word_valid=0.
REQ-018 While reset is low, clk edges SHALL have no effect.
REQ-019 Reset released mid-word SHALL restart framing: the first edge after release is bit 1 of a new word.
REQ-020 Reset asserted mid-word SHALL discard the partial word; no word_valid is produced for it.

Structure
REQ-021 No shared package SHALL be required; WIDTH and MSB_FIRST are module parameters, and the count width is derived locally with $clog2.
REQ-022 Implementation SHALL be a single module, with one always block for the shift register and one for counter/valid; no sub-module.
REQ-023 All outputs SHALL be flop outputs, with no combinational path from data_in to any output.

Verification
REQ-024 Hold reset low for 12 ns with clk period 10 ns and data_in toggling -> q=0000, bit_cnt=0, word_valid=0 throughout.
REQ-025 Release reset, then shift 1,0,1,1 (data_in changed mid-low-phase) -> q goes 0001, 0010, 0101, 1011; word_valid=1 only in the cycle after the 4th edge.
REQ-026 Shift 8 consecutive 1s after reset -> q saturates at 1111 after edge 4; word_valid pulses after edges 4 and 8; bit_cnt goes 1,2,3,0,1,2,3,0.
REQ-027 Assert reset asynchronously between edges with q=0110 and bit_cnt=2 -> q=0000 and bit_cnt=0 before the next edge; after release, the next word is framed from bit 1.
REQ-028 MSB_FIRST=0, WIDTH=8, shift 0x01 pattern bits 1,0,0,0,0,0,0,0 -> q=00000001 after edge 8 with word_valid pulse.
REQ-029 Random serial stream of 200 bits checked against a reference shift model -> q, bit_cnt and word_valid match every cycle.
